// File: rtl/boot_loader_uart.sv
// rtl/boot_loader_uart.sv - UART boot loader writing a word image into instruction memory; optional BOOT_CHECKSUM_EN
module boot_loader_uart #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0]      MAX_WORDS = 16'(1 << ADDR_W);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] L_LEN_LO = 3'd0;
   localparam logic [2:0] L_LEN_HI = 3'd1;
   localparam logic [2:0] L_DATA   = 3'd2;
   localparam logic [2:0] L_DONE   = 3'd4;
   localparam logic [2:0] L_ERR    = 3'd5;
`ifdef BOOT_CHECKSUM_EN
   localparam logic [2:0] L_CHK    = 3'd3;
   localparam logic [2:0] L_FINAL  = L_CHK;
`else
   localparam logic [2:0] L_FINAL  = L_DONE;
`endif

   logic             rx_meta;
   logic             rx_sync;
   logic             rx_prev;
   logic [1:0]       rx_state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       rx_shift;
   logic [7:0]       rx_byte;
   logic             byte_valid;
   logic             frame_err;

   logic [2:0]       l_state;
   logic [7:0]       len_lo;
   logic [15:0]      n_words;
   logic [ADDR_W:0]  word_idx;
   logic [1:0]       byte_idx;
   logic [23:0]      word_buf;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]       chk_xor;
`endif

   // Two-flop synchronizer for the asynchronous line, plus one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // 8N1 receiver: mid-bit sampling, start-bit glitch rejection, stop-bit framing check
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         rx_shift   <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               // the edge-detect cycle already counts toward the half-bit delay
               clk_cnt <= CNT_W'(1);
               bit_idx <= '0;
               if (rx_prev && !rx_sync) rx_state <= RX_START;
            end
            RX_START: begin
               if (clk_cnt >= HALF_CNT) begin
                  clk_cnt  <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == FULL_CNT) begin
                  clk_cnt  <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (clk_cnt == FULL_CNT) begin
                  clk_cnt  <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= rx_shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Loader: length capture, little-endian word assembly, memory writes, done/error tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         l_state    <= L_LEN_LO;
         len_lo     <= '0;
         n_words    <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         word_buf   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
`ifdef BOOT_CHECKSUM_EN
         chk_xor    <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         if (frame_err && l_state != L_DONE && l_state != L_ERR) begin
            l_state <= L_ERR;
         end else begin
            case (l_state)
               L_LEN_LO: begin
                  if (byte_valid) begin
                     len_lo  <= rx_byte;
                     l_state <= L_LEN_HI;
                  end
               end
               L_LEN_HI: begin
                  if (byte_valid) begin
                     n_words  <= {rx_byte, len_lo};
                     word_idx <= '0;
                     byte_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
                     chk_xor  <= '0;
`endif
                     if ({rx_byte, len_lo} == 16'd0) l_state <= L_FINAL;
                     else if ({rx_byte, len_lo} > MAX_WORDS) l_state <= L_ERR;
                     else l_state <= L_DATA;
                  end
               end
               L_DATA: begin
                  if (byte_valid) begin
                     byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                     chk_xor  <= chk_xor ^ rx_byte;
`endif
                     if (byte_idx == 2'd3) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx[ADDR_W-1:0];
                        imem_wdata <= {rx_byte, word_buf};
                        word_idx   <= word_idx + 1'b1;
                     end else begin
                        word_buf <= {rx_byte, word_buf[23:8]};
                     end
                  end else if (imem_we && 16'(word_idx) == n_words) begin
                     // leave one cycle after the final write so the release trails the last pulse
                     l_state <= L_FINAL;
                  end
               end
`ifdef BOOT_CHECKSUM_EN
               L_CHK: begin
                  if (byte_valid) l_state <= (rx_byte == chk_xor) ? L_DONE : L_ERR;
               end
`endif
               L_DONE:  l_state <= L_DONE;
               L_ERR:   l_state <= L_ERR;
               default: l_state <= L_ERR;
            endcase
         end
      end
   end

   assign cpu_reset = (l_state != L_DONE);
   assign load_done = (l_state == L_DONE);
   assign err       = (l_state == L_ERR);

endmodule

// File: tb/tb_boot_loader_uart.sv
// tb/tb_boot_loader_uart.sv - randomized and directed bench for boot_loader_uart against a byte-level loader model
module tb_boot_loader_uart;
   localparam int CPB = 4;
   localparam int AW  = 8;
`ifdef BOOT_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx = 1'b1;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_reset;
   logic          load_done;
   logic          err;

   int total = 0;
   int bad = 0;

   logic [39:0] exp_q[$];
   logic [39:0] exp_last;
   logic        exp_done;
   logic        exp_err;
   logic        exp_we_before_done;
   logic        prev_we = 1'b0;
   logic        prev_done = 1'b0;
   logic [39:0] mon_e;

   always #5 clk = ~clk;

   boot_loader_uart #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the byte stream through the loader rules, listing expected writes and end state
   task automatic model(input logic [8:0] s[$]);
      int st;
      int n;
      int bi;
      int wi;
      logic [7:0]  lo;
      logic [7:0]  x;
      logic [7:0]  b;
      logic [31:0] w;
      st = 0; n = 0; bi = 0; wi = 0; lo = '0; x = '0; w = '0;
      exp_q.delete();
      exp_last = '0;
      foreach (s[i]) begin
         b = s[i][7:0];
         if (st >= 4) continue;
         if (s[i][8]) begin
            st = 5;
            continue;
         end
         case (st)
            0: begin lo = b; st = 1; end
            1: begin
               n = int'({b, lo});
               if (n == 0) st = CHK_EN ? 3 : 4;
               else if (n > (1 << AW)) st = 5;
               else st = 2;
            end
            2: begin
               w = w | (32'(b) << (8 * bi));
               x = x ^ b;
               bi++;
               if (bi == 4) begin
                  exp_q.push_back({8'(wi), w});
                  exp_last = {8'(wi), w};
                  wi++;
                  bi = 0;
                  w = '0;
                  if (wi == n) st = CHK_EN ? 3 : 4;
               end
            end
            3: st = (b == x) ? 4 : 5;
            default: ;
         endcase
      end
      exp_done = (st == 4);
      exp_err  = (st == 5);
      exp_we_before_done = (n > 0) && !CHK_EN;
   endtask

   // Write monitor: every pulse matches the next expected word, pulses never adjacent, release trails last write
   always @(negedge clk) begin
      if (!reset) begin
         if (imem_we) begin
            chk("we_gap", 40'(prev_we), 40'd0);
            if (exp_q.size() == 0) begin
               chk("extra_we", 40'd1, 40'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("we_addr", 40'(imem_addr), 40'(mon_e[39:32]));
               chk("we_data", 40'(imem_wdata), 40'(mon_e[31:0]));
            end
         end
         if (load_done && !prev_done) chk("done_lat", 40'(prev_we), 40'(exp_we_before_done));
      end
      prev_we   = imem_we;
      prev_done = load_done;
   end

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [8:0] s);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(s[i], CPB);
      hold(~s[8], CPB);
      hold(1'b1, 2 * CPB);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_image(input string name, input logic [8:0] s[$], input bit glitch);
      model(s);
      do_reset();
      if (glitch) begin
         rx = 1'b0;
         @(negedge clk);
         rx = 1'b1;
         repeat (20) @(negedge clk);
      end
      foreach (s[i]) send_byte(s[i]);
      repeat (6) @(negedge clk);
      chk({name, "_done"}, 40'(load_done), 40'(exp_done));
      chk({name, "_err"}, 40'(err), 40'(exp_err));
      chk({name, "_cpurst"}, 40'(cpu_reset), 40'(!exp_done));
      chk({name, "_missing"}, 40'(exp_q.size()), 40'd0);
      chk({name, "_hold"}, {imem_addr, imem_wdata}, exp_last);
   endtask

   logic [8:0]  s[$];
   logic [15:0] n16;
   logic [7:0]  xs;
   logic [7:0]  rb;
   int          np;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_we", 40'(imem_we), 40'd0);
      chk("rst_addr", 40'(imem_addr), 40'd0);
      chk("rst_wdata", 40'(imem_wdata), 40'd0);
      chk("rst_cpurst", 40'(cpu_reset), 40'd1);
      chk("rst_done", 40'(load_done), 40'd0);
      chk("rst_err", 40'(err), 40'd0);

      s = '{9'h002, 9'h000, 9'h078, 9'h056, 9'h034, 9'h012, 9'h0EF, 9'h0BE, 9'h0AD, 9'h0DE, 9'h055, 9'h0AA};
      run_image("normal", s, 1'b0);
`ifndef BOOT_CHECKSUM_EN
      chk("normal_last_addr", 40'(imem_addr), 40'd1);
      chk("normal_last_data", 40'(imem_wdata), 40'hDEADBEEF);
`endif
      // reset after completion pulls the core back into reset on the next cycle
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rerst_done", 40'(load_done), 40'd0);
      chk("rerst_cpurst", 40'(cpu_reset), 40'd1);

`ifdef BOOT_CHECKSUM_EN
      s = '{9'h000, 9'h000, 9'h000};
`else
      s = '{9'h000, 9'h000};
`endif
      run_image("empty", s, 1'b0);

      s = '{9'h001, 9'h000, 9'h133, 9'h011, 9'h022, 9'h033, 9'h044};
      run_image("frame", s, 1'b0);

      s = '{9'h001, 9'h001, 9'h011, 9'h022, 9'h033, 9'h044};
      run_image("oversize", s, 1'b0);

      // partial word, then reset must discard it; the fresh load begins after a rejected glitch
      do_reset();
      send_byte(9'h001);
      send_byte(9'h000);
      send_byte(9'h011);
      send_byte(9'h022);
`ifdef BOOT_CHECKSUM_EN
      s = '{9'h001, 9'h000, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h000};
      s[6] = {1'b0, 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD};
`else
      s = '{9'h001, 9'h000, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD};
`endif
      run_image("glitch_reload", s, 1'b1);

`ifdef BOOT_CHECKSUM_EN
      s = '{9'h001, 9'h000, 9'h001, 9'h002, 9'h004, 9'h008, 9'h00F};
      run_image("cksum_ok", s, 1'b0);
      s = '{9'h001, 9'h000, 9'h001, 9'h002, 9'h004, 9'h008, 9'h00E};
      run_image("cksum_bad", s, 1'b0);
`endif

      for (int t = 0; t < 10; t++) begin
         s.delete();
         n16 = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) n16 = 16'(257 + $urandom_range(0, 3));
         s.push_back({1'b0, n16[7:0]});
         s.push_back({1'b0, n16[15:8]});
         np = (n16 > 16'd256) ? 4 : 4 * int'(n16);
         xs = '0;
         for (int k = 0; k < np; k++) begin
            rb = 8'($urandom);
            xs = xs ^ rb;
            s.push_back({1'b0, rb});
         end
         if (CHK_EN) s.push_back({1'b0, xs ^ 8'($urandom_range(0, 1))});
         for (int k = $urandom_range(0, 2); k > 0; k--) s.push_back({1'b0, 8'($urandom)});
         foreach (s[i]) if ($urandom_range(0, 11) == 0) s[i][8] = 1'b1;
         run_image($sformatf("rand%0d", t), s, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
